// File: rtl/mic_adc_capture_pkg.sv
// Shared constants, FSM state type and helpers for the microphone ADC capture path.
package mic_adc_capture_pkg;

  localparam int ADC_BITS       = 12;
  localparam int ADC_FRAME_BITS = 16;

  localparam logic [ADC_BITS-1:0] MIDSCALE = 12'd2048;
  localparam logic [ADC_BITS-1:0] MAG_MAX  = 12'd2047;

  localparam logic [3:0] LEVEL_NONE = 4'hF;
  localparam logic [3:0] LEVEL_MAX  = 4'd9;

  typedef enum logic [1:0] {IDLE, CONV, QUIET} adc_state_t;

  // Distance from midscale; a full-negative sample (2048 away) clamps so it fits 11 bits.
  function automatic logic [ADC_BITS-1:0] mid_distance(input logic [ADC_BITS-1:0] s);
    logic [ADC_BITS-1:0] d;
    d = (s >= MIDSCALE) ? (s - MIDSCALE) : (MIDSCALE - s);
    if (d > MAG_MAX) begin
      d = MAG_MAX;
    end
    return d;
  endfunction

endpackage

// File: rtl/mic_peak_meter.sv
// Windowed peak-magnitude meter producing the 0..9 loudness digit from captured samples.
module mic_peak_meter
  import mic_adc_capture_pkg::*;
#(
  parameter int PEAK_WINDOW = 2000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADC_BITS-1:0] sample,
  input  logic                sample_valid,
  output logic [3:0]          level
);

  localparam int            CW       = $clog2(PEAK_WINDOW + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(PEAK_WINDOW - 1);

  logic [CW-1:0]       win_cnt_reg;
  logic [ADC_BITS-1:0] peak_reg;
  logic [ADC_BITS-1:0] peak_next;
  logic [ADC_BITS-1:0] mag;
  logic [4:0]          bucket;
  logic [3:0]          level_reg;
  logic [3:0]          level_next;

  always_comb begin
    mag       = mid_distance(sample);
    peak_next = (mag > peak_reg) ? mag : peak_reg;
    bucket    = peak_next[ADC_BITS-1:7];
    level_next = (bucket > 5'(LEVEL_MAX)) ? LEVEL_MAX : bucket[3:0];
  end

  // The window's last sample is folded into the published level, not the next peak.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cnt_reg <= '0;
      peak_reg    <= '0;
      level_reg   <= LEVEL_NONE;
    end else if (sample_valid) begin
      if (win_cnt_reg == WIN_LAST) begin
        win_cnt_reg <= '0;
        peak_reg    <= '0;
        level_reg   <= level_next;
      end else begin
        win_cnt_reg <= win_cnt_reg + CW'(1);
        peak_reg    <= peak_next;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/mic_adc_capture.sv
// Periodic SPI-style capture of the 12-bit microphone ADC (16-SCLK frame, MSB first).
// Define MIC_PEAK_LEVEL_EN to build the loudness meter; otherwise level reads 4'hF.
module mic_adc_capture
  import mic_adc_capture_pkg::*;
#(
  parameter int SCLK_DIV    = 4,
  parameter int SAMPLE_DIV  = 5000,
  parameter int PEAK_WINDOW = 2000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic [ADC_BITS-1:0] sample,
  output logic                sample_valid,
  output logic                overrun,
  output logic [3:0]          level
);

  localparam int            TW         = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [7:0]    HP_LAST    = 8'(SCLK_DIV - 1);
  localparam logic [8:0]    QUIET_LAST = 9'(2 * SCLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(ADC_FRAME_BITS - 1);

  if (SCLK_DIV < 2 || SCLK_DIV > 255 || PEAK_WINDOW < 1) begin : g_param_check
    $error("mic_adc_capture: SCLK_DIV must be 2..255 and PEAK_WINDOW at least 1");
  end

  adc_state_t                state_reg, state_next;
  logic [1:0]                miso_sync_reg;
  logic [TW-1:0]             tick_cnt_reg;
  logic                      tick_reg;
  logic [7:0]                hp_cnt_reg, hp_cnt_next;
  logic                      sclk_reg, sclk_next;
  logic [3:0]                bit_cnt_reg, bit_cnt_next;
  logic [ADC_FRAME_BITS-1:0] shift_reg, shift_next;
  logic [8:0]                quiet_cnt_reg, quiet_cnt_next;
  logic [ADC_BITS-1:0]       sample_reg, sample_next;
  logic                      valid_reg, valid_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miso_sync_reg <= '0;
      tick_cnt_reg  <= '0;
      tick_reg      <= 1'b0;
      state_reg     <= IDLE;
      hp_cnt_reg    <= '0;
      sclk_reg      <= 1'b1;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      quiet_cnt_reg <= '0;
      sample_reg    <= '0;
      valid_reg     <= 1'b0;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], miso};
      tick_cnt_reg  <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + TW'(1);
      tick_reg      <= (tick_cnt_reg == TICK_LAST);
      state_reg     <= state_next;
      hp_cnt_reg    <= hp_cnt_next;
      sclk_reg      <= sclk_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      quiet_cnt_reg <= quiet_cnt_next;
      sample_reg    <= sample_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hp_cnt_next    = '0;
    sclk_next      = 1'b1;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    quiet_cnt_next = '0;
    sample_next    = sample_reg;
    valid_next     = 1'b0;
    cs_n           = 1'b1;
    overrun        = 1'b0;
    case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        if (tick_reg && enable) begin
          state_next = CONV;
        end
      end
      CONV: begin
        cs_n        = 1'b0;
        overrun     = tick_reg;
        sclk_next   = sclk_reg;
        hp_cnt_next = hp_cnt_reg + 8'd1;
        if (hp_cnt_reg == HP_LAST) begin
          hp_cnt_next = '0;
          sclk_next   = ~sclk_reg;
          // Capture on the cycle that drives sclk high; the ADC changed miso on the fall.
          if (!sclk_reg) begin
            shift_next   = ADC_FRAME_BITS'({shift_reg, miso_sync_reg[1]});
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST_BIT) begin
              state_next = QUIET;
            end
          end
        end
      end
      QUIET: begin
        overrun        = tick_reg;
        quiet_cnt_next = quiet_cnt_reg + 9'd1;
        if (quiet_cnt_reg == '0) begin
          sample_next = shift_reg[ADC_BITS-1:0];
          valid_next  = 1'b1;
        end
        if (quiet_cnt_reg == QUIET_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sclk         = sclk_reg;
  assign sample       = sample_reg;
  assign sample_valid = valid_reg;

`ifdef MIC_PEAK_LEVEL_EN
  mic_peak_meter #(
    .PEAK_WINDOW(PEAK_WINDOW)
  ) u_peak (
    .clock       (clock),
    .reset       (reset),
    .sample      (sample_reg),
    .sample_valid(valid_reg),
    .level       (level)
  );
`else
  assign level = LEVEL_NONE;
`endif

endmodule

// File: tb/tb_mic_adc_capture.sv
// Scoreboard bench: dut_a runs the default timing, dut_b a fast overrunning setup with a 4-sample window.
module tb_mic_adc_capture;

  typedef struct {
    logic [11:0] data;
    int          at;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b, en_a, en_b;
  logic        miso_a = 1'b0, miso_b = 1'b0;
  logic        cs_n_a, sclk_a, sv_a, ov_a, cs_n_b, sclk_b, sv_b, ov_b;
  logic [11:0] sample_a, sample_b;
  logic [3:0]  level_a, level_b;

  int checks = 0;
  int failures = 0;
  int ecnt_a = 0, ecnt_b = 0;
  int cs_low_a = 0, low_w_a = 0, pulses_a = 0, frames_a = 0;
  logic cs_prev_a = 1'b1;

  exp_t        sb_a[$], sb_b[$];
  int          ov_q_b[$];
  logic [15:0] adc_q_a[$], adc_q_b[$];

  mic_adc_capture dut_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .miso(miso_a), .cs_n(cs_n_a), .sclk(sclk_a),
    .sample(sample_a), .sample_valid(sv_a), .overrun(ov_a), .level(level_a)
  );

  mic_adc_capture #(.SCLK_DIV(4), .SAMPLE_DIV(100), .PEAK_WINDOW(4)) dut_b (
    .clock(clock), .reset(rst_b), .enable(en_b), .miso(miso_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .sample(sample_b), .sample_valid(sv_b), .overrun(ov_b), .level(level_b)
  );

  // Clock edges since reset release; edge N is the Nth rising edge with reset low.
  always @(posedge clock) begin
    ecnt_a <= rst_a ? 0 : ecnt_a + 1;
    ecnt_b <= rst_b ? 0 : ecnt_b + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [15:0] w, input int at);
    exp_t e;
    adc_q_a.push_back(w);
    e.data = w[11:0];
    e.at   = at;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] w, input int at);
    exp_t e;
    adc_q_b.push_back(w);
    e.data = w[11:0];
    e.at   = at;
    sb_b.push_back(e);
  endtask

  task automatic wait_a(input int n);
    while (ecnt_a < n) @(negedge clock);
  endtask

  task automatic wait_b(input int n);
    while (ecnt_b < n) @(negedge clock);
  endtask

  // ADC models: first bit appears on the first sclk fall after cs_n drops.
  initial begin : adc_a
    logic [15:0] word;
    int idx;
    word = '0;
    idx  = 0;
    forever begin
      @(negedge cs_n_a or negedge sclk_a);
      if (cs_n_a === 1'b0) begin
        if (sclk_a === 1'b1) begin
          word = (adc_q_a.size() > 0) ? adc_q_a.pop_front() : 16'h0000;
          idx  = 16;
        end else if (idx > 0) begin
          idx--;
          miso_a = word[idx];
        end
      end
    end
  end

  initial begin : adc_b
    logic [15:0] word;
    int idx;
    word = '0;
    idx  = 0;
    forever begin
      @(negedge cs_n_b or negedge sclk_b);
      if (cs_n_b === 1'b0) begin
        if (sclk_b === 1'b1) begin
          word = (adc_q_b.size() > 0) ? adc_q_b.pop_front() : 16'h0000;
          idx  = 16;
        end else if (idx > 0) begin
          idx--;
          miso_b = word[idx];
        end
      end
    end
  end

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clock);
      if (rst_a) begin
        cs_low_a  = 0;
        low_w_a   = 0;
        pulses_a  = 0;
        cs_prev_a = 1'b1;
      end else begin
        if (sv_a) begin
          chk("a_valid_expected", 32'(sb_a.size() > 0), 32'd1);
          if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            chk("a_sample", 32'(sample_a), 32'(e.data));
            chk("a_valid_cycle", ecnt_a, e.at);
            $display("a: sample=0x%03h at edge %0d", sample_a, ecnt_a);
          end
        end
        if (ov_a) chk("a_overrun_unexpected", 32'(ov_a), 32'd0);
        if (!sclk_a) begin
          low_w_a++;
        end else if (low_w_a > 0) begin
          chk("a_sclk_low_width", low_w_a, 4);
          pulses_a++;
          low_w_a = 0;
        end
        if (!cs_n_a) begin
          cs_low_a++;
        end else if (!cs_prev_a) begin
          chk("a_cs_low_cycles", cs_low_a, 128);
          chk("a_sclk_pulses", pulses_a, 16);
          frames_a++;
          cs_low_a = 0;
          pulses_a = 0;
        end
        cs_prev_a = cs_n_a;
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    int o;
    forever begin
      @(negedge clock);
      if (!rst_b) begin
        if (sv_b) begin
          chk("b_valid_expected", 32'(sb_b.size() > 0), 32'd1);
          if (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            chk("b_sample", 32'(sample_b), 32'(e.data));
            chk("b_valid_cycle", ecnt_b, e.at);
            $display("b: sample=0x%03h at edge %0d", sample_b, ecnt_b);
          end
        end
        if (ov_b) begin
          chk("b_overrun_expected", 32'(ov_q_b.size() > 0), 32'd1);
          if (ov_q_b.size() > 0) begin
            o = ov_q_b.pop_front();
            chk("b_overrun_cycle", ecnt_b, o);
            $display("b: overrun at edge %0d", ecnt_b);
          end
        end
      end
    end
  end

  task automatic run_a();
    int f_after;
    // Three periodic frames; the third has junk in the ignored top nibble.
    push_a(16'h0AC3, 5130);
    push_a(16'h0555, 10130);
    push_a(16'hF123, 15130);
    wait_a(15140);
    chk("a_sample_hold", 32'(sample_a), 32'h123);
    // Fourth frame is aborted by reset at the 8th sclk edge.
    adc_q_a.push_back(16'h0FFF);
    wait_a(20033);
    chk("a_midframe_cs_n", 32'(cs_n_a), 32'd0);
    chk("a_midframe_sclk", 32'(sclk_a), 32'd1);
    rst_a = 1'b1;
    #1;
    chk("a_abort_cs_n", 32'(cs_n_a), 32'd1);
    chk("a_abort_sclk", 32'(sclk_a), 32'd1);
    chk("a_abort_sample", 32'(sample_a), 32'd0);
    chk("a_abort_valid", 32'(sv_a), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst_a = 1'b0;
    push_a(16'h0ABC, 5130);
    push_a(16'h0321, 10130);
    wait_a(10050);
    en_a = 1'b0;
    wait_a(10140);
    f_after = frames_a;
    wait_a(20200);
    chk("a_frames_after_disable", frames_a, f_after);
    chk("a_cs_n_disabled", 32'(cs_n_a), 32'd1);
  endtask

  task automatic run_b();
    logic [15:0] words [12];
    logic [3:0]  lvls [12];
    words = '{16'h0800, 16'h09C4, 16'h03E8, 16'h0834,
              16'h0800, 16'h0800, 16'h0800, 16'h0800,
              16'h0000, 16'h0800, 16'h0800, 16'h0800};
`ifdef MIC_PEAK_LEVEL_EN
    lvls = '{4'hF, 4'hF, 4'hF, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9};
`else
    lvls = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`endif
    for (int k = 0; k < 12; k++) begin
      push_b(words[k], 230 + 200 * k);
      ov_q_b.push_back(200 + 200 * k);
    end
    wait_b(50);
    chk("b_level_initial", 32'(level_b), 32'hF);
    for (int k = 0; k < 12; k++) begin
      wait_b(232 + 200 * k);
      chk($sformatf("b_level_after_%0d", k + 1), 32'(level_b), 32'(lvls[k]));
    end
    wait_b(2450);
    en_b = 1'b0;
    wait_b(2700);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_cs_n", 32'(cs_n_a), 32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd1);
    chk("rst_sample", 32'(sample_a), 32'd0);
    chk("rst_valid", 32'(sv_a), 32'd0);
    chk("rst_overrun", 32'(ov_a), 32'd0);
    chk("rst_level", 32'(level_a), 32'hF);
    rst_a = 1'b0;
    rst_b = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;
    fork
      run_a();
      run_b();
    join
    chk("a_scoreboard_drained", sb_a.size(), 0);
    chk("b_scoreboard_drained", sb_b.size(), 0);
    chk("b_overrun_drained", ov_q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
